// File: rtl/lowpass_biquad.sv
// rtl/lowpass_biquad.sv - two cascaded one-pole IIR low-pass sections, one frame per 3 clocks
module lowpass_biquad (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         filter,
  input  logic signed [15:0] lowpassIn,
  output logic signed [15:0] lowpassOut
);

  logic        [1:0]  ph;
  logic signed [15:0] x_reg;
  logic        [1:0]  mode_reg;
  logic signed [23:0] s1;
  logic signed [23:0] s2;

  logic signed [23:0] xe;
  logic        [2:0]  k;
  logic signed [24:0] d1;
  logic signed [24:0] d2;
  logic signed [23:0] d1_sh;
  logic signed [23:0] d2_sh;
  logic signed [23:0] s1_next;
  logic signed [23:0] s2_next;

  // Mode 1/2/3 maps to shift 2/4/6.
  assign k  = {mode_reg, 1'b0};
  assign xe = {x_reg, 8'd0};

  // Each step is convex toward its target, so the shifted difference fits 24 bits.
  assign d1      = {xe[23], xe} - {s1[23], s1};
  assign d1_sh   = 24'(d1 >>> k);
  assign s1_next = s1 + d1_sh;

  assign d2      = {s1[23], s1} - {s2[23], s2};
  assign d2_sh   = 24'(d2 >>> k);
  assign s2_next = s2 + d2_sh;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      ph         <= 2'd0;
      x_reg      <= '0;
      mode_reg   <= 2'd0;
      s1         <= '0;
      s2         <= '0;
      lowpassOut <= '0;
    end else begin
      case (ph)
        2'd0: begin
          x_reg    <= lowpassIn;
          mode_reg <= filter;
          ph       <= 2'd1;
        end
        2'd1: begin
          s1 <= (mode_reg == 2'd0) ? xe : s1_next;
          ph <= 2'd2;
        end
        default: begin
          if (mode_reg == 2'd0) begin
            s2         <= xe;
            lowpassOut <= x_reg;
          end else begin
            s2         <= s2_next;
            lowpassOut <= 16'(s2_next >>> 8);
          end
          ph <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lowpass_biquad.sv
// tb/tb_lowpass_biquad.sv - scoreboard bench for lowpass_biquad
module tb_lowpass_biquad;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [1:0]         filter;
  logic signed [15:0] lowpassIn;
  logic signed [15:0] lowpassOut;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int m_s1;
  int m_s2;
  int prev_exp;
  int sine[16];

  lowpass_biquad dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .filter     (filter),
    .lowpassIn  (lowpassIn),
    .lowpassOut (lowpassOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference: y += floor((target - y) / 2^k) on Q16.8 integers.
  function automatic int model_frame(input int x, input int f);
    int xe;
    int k;
    xe = x * 256;
    k  = 2 * f;
    if (f == 0) begin
      m_s1 = xe;
      m_s2 = xe;
      return x;
    end
    m_s1 = m_s1 + ((xe - m_s1) >>> k);
    m_s2 = m_s2 + ((m_s1 - m_s2) >>> k);
    return m_s2 >>> 8;
  endfunction

  task automatic drive_frame(input int x, input int f, output int obs);
    int want;
    lowpassIn = 16'(x);
    filter    = 2'(f);
    exp_q.push_back(model_frame(x, f));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("hold", int'(lowpassOut), prev_exp);
    end
    @(posedge clk); #1;
    obs = int'(lowpassOut);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      want = exp_q.pop_front();
      check("frame", obs, want);
      prev_exp = want;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b1;
    lowpassIn = 16'sd32767;
    filter    = 2'd3;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_out", int'(lowpassOut), 0);
    end
    reset_n  = 1'b0;
    m_s1     = 0;
    m_s2     = 0;
    prev_exp = 0;
    exp_q.delete();
  endtask

  task automatic run_sine(input int f, output int peak);
    int obs;
    int mag;
    peak = 0;
    for (int p = 0; p < 40; p++) begin
      for (int n = 0; n < 16; n++) begin
        drive_frame(sine[n], f, obs);
        mag = (obs < 0) ? -obs : obs;
        if (mag > peak) peak = mag;
      end
    end
  endtask

  initial begin
    int obs;
    int prev_obs;
    int mono;
    int peak1;
    int peak3;

    sine = '{0, 12540, 23170, 30273, 32767, 30273, 23170, 12540,
             0, -12540, -23170, -30273, -32767, -30273, -23170, -12540};
    reset_n   = 1'b1;
    filter    = 2'd0;
    lowpassIn = '0;

    do_reset();
    drive_frame(12540, 0, obs);
    check("byp_a", obs, 12540);
    drive_frame(-23170, 0, obs);
    check("byp_b", obs, -23170);

    do_reset();
    drive_frame(32767, 1, obs);
    check("pos_s1", int'(dut.s1), 2097088);
    check("pos_s2", int'(dut.s2), 524272);
    check("pos_out1", obs, 2047);
    mono     = 1;
    prev_obs = obs;
    for (int i = 1; i < 200; i++) begin
      drive_frame(32767, 1, obs);
      if (obs < prev_obs) mono = 0;
      prev_obs = obs;
    end
    check("pos_mono", mono, 1);
    check("pos_final", int'(obs == 32766 || obs == 32767), 1);

    do_reset();
    drive_frame(-32767, 1, obs);
    check("neg_s1", int'(dut.s1), -2097088);
    check("neg_s2", int'(dut.s2), -524272);
    check("neg_out1", obs, -2048);
    for (int i = 1; i < 200; i++) drive_frame(-32767, 1, obs);
    check("neg_final", obs, -32767);

    do_reset();
    run_sine(1, peak1);
    do_reset();
    run_sine(3, peak3);
    check("atten_lt", int'(peak3 < peak1), 1);
    check("atten_max", int'(peak1 <= 32767), 1);

    do_reset();
    for (int i = 0; i < 10; i++) drive_frame(32767, 2, obs);
    drive_frame(32767, 0, obs);
    check("sw_byp", obs, 32767);
    drive_frame(32767, 2, obs);
    check("sw_back", obs, 32767);

    lowpassIn = 16'sd1234;
    filter    = 2'd2;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", int'(lowpassOut), 0);
    reset_n  = 1'b0;
    m_s1     = 0;
    m_s2     = 0;
    prev_exp = 0;
    exp_q.delete();
    drive_frame(5000, 0, obs);
    check("mid_restart", obs, 5000);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
